// File: rtl/mips_mon_pkg.sv
// Shared types and constants for the data-memory write monitor.
package mips_mon_pkg;

   typedef enum logic [1:0] {
      RESET_ST = 2'b00,
      RUN      = 2'b01,
      PASS_ST  = 2'b10,
      FAIL_ST  = 2'b11
   } mon_state_t;

   localparam logic [1:0] FC_NONE    = 2'b00;
   localparam logic [1:0] FC_DATA    = 2'b01;
   localparam logic [1:0] FC_TIMEOUT = 2'b10;
   localparam logic [1:0] FC_ALIGN   = 2'b11;

   localparam logic [31:0] DEF_TARGET_ADR  = 32'd84;
   localparam logic [31:0] DEF_TARGET_DATA = 32'd7;

endpackage

// File: rtl/mem_write_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_write_monitor.sv
// Watches the processor's data-memory store port and latches a sticky PASS/FAIL verdict.
// Optional misaligned-store check is enabled by defining MEM_MON_ALIGN_CHECK_EN.
module mem_write_monitor
   import mips_mon_pkg::*;
#(
   parameter logic [31:0] TARGET_ADR     = DEF_TARGET_ADR,
   parameter logic [31:0] TARGET_DATA    = DEF_TARGET_DATA,
   parameter int          TIMEOUT_CYCLES = 1000,
   parameter int          CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             memwrite,
   input  logic [31:0]      dataadr,
   input  logic [31:0]      writedata,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [1:0]       fail_code,
   output logic [CNT_W-1:0] store_count,
   output logic [CNT_W-1:0] cycle_count,
   output logic [31:0]      last_adr,
   output logic [31:0]      last_data
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_min
      $error("mem_write_monitor: TIMEOUT_CYCLES must be at least 1");
   end

   // The timeout compare needs TIMEOUT_CYCLES-1 to be reachable by a saturating counter.
   if (longint'(TIMEOUT_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_timeout_max
      $error("mem_write_monitor: TIMEOUT_CYCLES exceeds 2**CNT_W");
   end

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   mon_state_t state;
   logic       in_run;
   logic       target_hit;
   logic       data_ok;
   logic       timeout_hit;

   assign in_run      = (state == RUN);
   assign target_hit  = memwrite && (dataadr == TARGET_ADR);
   assign data_ok     = (writedata == TARGET_DATA);
   assign timeout_hit = (cycle_count == TIMEOUT_LAST);

`ifdef MEM_MON_ALIGN_CHECK_EN
   logic misaligned;
   assign misaligned = memwrite && (dataadr[1:0] != 2'b00);
`endif

   sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .clr   (reset),
      .inc   (in_run),
      .count (cycle_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_store_cnt (
      .clk   (clk),
      .clr   (reset),
      .inc   (in_run && memwrite),
      .count (store_count)
   );

   // Verdict priority in RUN: alignment (if enabled), then target store, then timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RESET_ST;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         fail_code <= FC_NONE;
         last_adr  <= '0;
         last_data <= '0;
      end else begin
         case (state)
            RESET_ST: begin
               state <= RUN;
            end
            RUN: begin
               if (memwrite) begin
                  last_adr  <= dataadr;
                  last_data <= writedata;
               end
`ifdef MEM_MON_ALIGN_CHECK_EN
               if (misaligned) begin
                  state     <= FAIL_ST;
                  fail      <= 1'b1;
                  done      <= 1'b1;
                  fail_code <= FC_ALIGN;
               end else
`endif
               if (target_hit && data_ok) begin
                  state <= PASS_ST;
                  pass  <= 1'b1;
                  done  <= 1'b1;
               end else if (target_hit) begin
                  state     <= FAIL_ST;
                  fail      <= 1'b1;
                  done      <= 1'b1;
                  fail_code <= FC_DATA;
               end else if (timeout_hit) begin
                  state     <= FAIL_ST;
                  fail      <= 1'b1;
                  done      <= 1'b1;
                  fail_code <= FC_TIMEOUT;
               end
            end
            PASS_ST: begin
               state <= PASS_ST;
            end
            FAIL_ST: begin
               state <= FAIL_ST;
            end
            default: begin
               state <= RESET_ST;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed self-checking bench for mem_write_monitor: vector table plus multi-cycle sequences.
module tb_mem_write_monitor;

`ifdef MEM_MON_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;

   logic        done, pass, fail;
   logic [1:0]  fail_code;
   logic [15:0] store_count, cycle_count;
   logic [31:0] last_adr, last_data;

   logic        s_done, s_pass, s_fail;
   logic [1:0]  s_fail_code;
   logic [3:0]  s_store_count, s_cycle_count;
   logic [31:0] s_last_adr, s_last_data;

   int checks = 0;
   int errors = 0;

   mem_write_monitor #(
      .TARGET_ADR(32'd84), .TARGET_DATA(32'd7), .TIMEOUT_CYCLES(20), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .done(done), .pass(pass), .fail(fail),
      .fail_code(fail_code), .store_count(store_count), .cycle_count(cycle_count),
      .last_adr(last_adr), .last_data(last_data)
   );

   // Narrow instance so that counter saturation is reachable in a few cycles.
   mem_write_monitor #(
      .TARGET_ADR(32'd84), .TARGET_DATA(32'd7), .TIMEOUT_CYCLES(16), .CNT_W(4)
   ) dut_sat (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .done(s_done), .pass(s_pass), .fail(s_fail),
      .fail_code(s_fail_code), .store_count(s_store_count), .cycle_count(s_cycle_count),
      .last_adr(s_last_adr), .last_data(s_last_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        mw;
      int          idle;
      logic [31:0] adr;
      logic [31:0] data;
      logic        ep;
      logic        ef;
      logic [1:0]  ecode;
      int          estore;
      int          ecycle;
      logic [31:0] eadr;
      logic [31:0] edata;
   } vec_t;

   vec_t vecs[8];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkAll(input string tag, input logic ep, input logic ef, input logic [1:0] ecode,
                           input int estore, input int ecycle, input logic [31:0] eadr,
                           input logic [31:0] edata);
      checkOutput({tag, "_pass"}, 32'(pass), 32'(ep));
      checkOutput({tag, "_fail"}, 32'(fail), 32'(ef));
      checkOutput({tag, "_done"}, 32'(done), 32'(ep | ef));
      checkOutput({tag, "_code"}, 32'(fail_code), 32'(ecode));
      checkOutput({tag, "_stores"}, 32'(store_count), 32'(estore));
      checkOutput({tag, "_cycles"}, 32'(cycle_count), 32'(ecycle));
      checkOutput({tag, "_last_adr"}, last_adr, eadr);
      checkOutput({tag, "_last_data"}, last_data, edata);
   endtask

   // Called at a negedge; returns at the next negedge after one clock edge has used the inputs.
   task automatic applyStimulus(input logic mw, input logic [31:0] adr, input logic [31:0] data);
      memwrite  = mw;
      dataadr   = adr;
      writedata = data;
      @(negedge clk);
   endtask

   // Returns at a negedge with the monitor in RUN and cycle_count still 0.
   task automatic resetDut();
      @(negedge clk);
      reset    = 1'b1;
      memwrite = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b1, 4,  32'd84, 32'd7, 1'b1, 1'b0, 2'b00, 1, 5,  32'd84, 32'd7};
      vecs[1] = '{1'b1, 0,  32'd84, 32'd9, 1'b0, 1'b1, 2'b01, 1, 1,  32'd84, 32'd9};
      vecs[2] = '{1'b1, 19, 32'd84, 32'd7, 1'b1, 1'b0, 2'b00, 1, 20, 32'd84, 32'd7};
      vecs[3] = '{1'b1, 19, 32'd84, 32'd8, 1'b0, 1'b1, 2'b01, 1, 20, 32'd84, 32'd8};
      vecs[4] = '{1'b1, 2,  32'd86, 32'd7, 1'b0, ALIGN_EN, ALIGN_EN ? 2'b11 : 2'b00,
                  1, 3, 32'd86, 32'd7};
      vecs[5] = '{1'b1, 3,  32'd80, 32'd7, 1'b0, 1'b0, 2'b00, 1, 4,  32'd80, 32'd7};
      vecs[6] = '{1'b0, 2,  32'd84, 32'd7, 1'b0, 1'b0, 2'b00, 0, 3,  32'd0,  32'd0};
      vecs[7] = '{1'b1, 19, 32'd85, 32'd7, 1'b0, 1'b1, ALIGN_EN ? 2'b11 : 2'b10,
                  1, 20, 32'd85, 32'd7};

      reset     = 1'b1;
      memwrite  = 1'b0;
      dataadr   = '0;
      writedata = '0;
      #22 reset = 1'b0;
      @(negedge clk);
      $display("[TB] power-up reset released, alignment check enabled = %0d", ALIGN_EN);
      checkAll("reset", 1'b0, 1'b0, 2'b00, 0, 0, 32'd0, 32'd0);

      for (int i = 0; i < 8; i++) begin
         resetDut();
         for (int k = 0; k < vecs[i].idle; k++) applyStimulus(1'b0, 32'd0, 32'd0);
         applyStimulus(vecs[i].mw, vecs[i].adr, vecs[i].data);
         memwrite = 1'b0;
         checkAll($sformatf("vec%0d", i), vecs[i].ep, vecs[i].ef, vecs[i].ecode,
                  vecs[i].estore, vecs[i].ecycle, vecs[i].eadr, vecs[i].edata);
      end

      // Non-target store followed by a wrong value at the target.
      resetDut();
      applyStimulus(1'b1, 32'd80, 32'd3);
      applyStimulus(1'b1, 32'd84, 32'd9);
      memwrite = 1'b0;
      checkAll("two_stores", 1'b0, 1'b1, 2'b01, 2, 2, 32'd84, 32'd9);

      // Timeout with no stores, then verify the counters freeze.
      resetDut();
      for (int k = 0; k < 19; k++) applyStimulus(1'b0, 32'd0, 32'd0);
      checkOutput("pre_timeout_done", 32'(done), 32'd0);
      checkOutput("pre_timeout_cycles", 32'(cycle_count), 32'd19);
      applyStimulus(1'b0, 32'd0, 32'd0);
      checkAll("timeout", 1'b0, 1'b1, 2'b10, 0, 20, 32'd0, 32'd0);
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'd84, 32'd7);
      checkAll("timeout_frozen", 1'b0, 1'b1, 2'b10, 0, 20, 32'd0, 32'd0);

      // Freeze after PASS, then a one-cycle reset pulse returns to power-up state.
      resetDut();
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 32'd0, 32'd0);
      applyStimulus(1'b1, 32'd84, 32'd7);
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'd84, 32'd1);
      checkAll("pass_frozen", 1'b1, 1'b0, 2'b00, 1, 5, 32'd84, 32'd7);
      memwrite = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkAll("after_pulse", 1'b0, 1'b0, 2'b00, 0, 0, 32'd0, 32'd0);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 32'd0);
      checkOutput("rerun_cycles", 32'(cycle_count), 32'd1);

      // Continuous stores: narrow counters saturate while the timeout still fires.
      resetDut();
      for (int k = 0; k < 15; k++) applyStimulus(1'b1, 32'd0, 32'h55);
      checkOutput("sat_pre_done", 32'(s_done), 32'd0);
      checkOutput("sat_pre_cycles", 32'(s_cycle_count), 32'd15);
      applyStimulus(1'b1, 32'd0, 32'h55);
      checkOutput("sat_fail", 32'(s_fail), 32'd1);
      checkOutput("sat_code", 32'(s_fail_code), 32'd2);
      checkOutput("sat_cycles", 32'(s_cycle_count), 32'd15);
      checkOutput("sat_stores", 32'(s_store_count), 32'd15);
      memwrite = 1'b0;
      checkAll("wide_running", 1'b0, 1'b0, 2'b00, 16, 16, 32'd0, 32'h55);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
